huff_encoder_stream: RTL and testbench

Parametrised successor to the fixed 3-symbol Huffman encoder. It accepts up to MAX_CHAR_COUNT (character, frequency) pairs over a valid/ready stream and builds the Huffman tree sequentially, one merge per cycle. It then derives canonical-tie-ruled codes top-down and emits one (char, code, length) beat per symbol, with output backpressure. It sits between the symbol-statistics front end and the bit packer.

---
 rtl/huff_encoder_stream.sv | 207 ++++++++++++++++++++
 tb/tb_huff_encoder_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/huff_encoder_stream.sv
// Streaming Huffman encoder: loads up to MAX_CHAR_COUNT (char, freq) pairs, builds the tree
// one merge per cycle, assigns codes top-down, then emits one (char, code, len) beat per symbol.
module huff_encoder_stream #(
    parameter int MAX_CHAR_COUNT = 4,
    parameter int CHAR_W         = 8,
    parameter int FREQ_W         = 4,
    parameter int CODE_W         = MAX_CHAR_COUNT - 1,
    parameter int WGT_W          = FREQ_W + $clog2(MAX_CHAR_COUNT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHAR_W-1:0]            in_char,
    input  logic [FREQ_W-1:0]            in_freq,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHAR_W-1:0]            out_char,
    output logic [CODE_W-1:0]            out_code,
    output logic [$clog2(CODE_W+1)-1:0]  out_len,
    output logic                         done
);

    localparam int unsigned NODES = 2 * MAX_CHAR_COUNT - 1;
    localparam int unsigned IDX_W = $clog2(NODES);
    localparam int unsigned LEN_W = $clog2(CODE_W + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {ST_LOAD, ST_BUILD, ST_CODE, ST_EMIT} state_t;

    state_t             state;
    logic [WGT_W-1:0]   weight   [NODES];
    logic [NODES-1:0]   active;
    idx_t               left_c   [NODES];
    idx_t               right_c  [NODES];
    logic [CODE_W-1:0]  code     [NODES];
    logic [LEN_W-1:0]   len      [NODES];
    logic [CHAR_W-1:0]  chars    [NODES];

    idx_t k;
    idx_t xfer_cnt;
    idx_t node_ptr;
    idx_t root_idx;
    idx_t emit_idx;

    // Two smallest active weights; strict compare in ascending index order gives lower-index ties.
    idx_t             sel_a, sel_b;
    logic [WGT_W-1:0] w_a, w_b;
    logic             found_a, found_b;

    always_comb begin
        sel_a   = '0;
        w_a     = '0;
        found_a = 1'b0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (active[i] && (!found_a || weight[i] < w_a)) begin
                found_a = 1'b1;
                w_a     = weight[i];
                sel_a   = idx_t'(i);
            end
        end
        sel_b   = '0;
        w_b     = '0;
        found_b = 1'b0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (active[i] && idx_t'(i) != sel_a && (!found_b || weight[i] < w_b)) begin
                found_b = 1'b1;
                w_b     = weight[i];
                sel_b   = idx_t'(i);
            end
        end
    end

    logic in_fire, keep, load_exit;
    idx_t k_next;

    always_comb begin
        in_fire   = in_valid && in_ready;
        keep      = (in_freq != '0);
        k_next    = k + idx_t'(keep);
        load_exit = in_last || (xfer_cnt == idx_t'(MAX_CHAR_COUNT - 1));
    end

    idx_t              beat_idx;
    logic [CHAR_W-1:0] beat_char;
    logic [CODE_W-1:0] beat_code;
    logic [LEN_W-1:0]  beat_len;
    logic              emit_last;

    always_comb begin
        beat_idx  = out_valid ? emit_idx + 1'b1 : emit_idx;
        beat_char = chars[beat_idx];
        beat_code = (k == idx_t'(1)) ? '0 : code[beat_idx];
        beat_len  = (k == idx_t'(1)) ? LEN_W'(1) : len[beat_idx];
        emit_last = (emit_idx == k - 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_char  <= '0;
            out_code  <= '0;
            out_len   <= '0;
            k         <= '0;
            xfer_cnt  <= '0;
            node_ptr  <= '0;
            root_idx  <= '0;
            emit_idx  <= '0;
            active    <= '0;
            for (int unsigned i = 0; i < NODES; i++) begin
                weight[i]  <= '0;
                left_c[i]  <= '0;
                right_c[i] <= '0;
                code[i]    <= '0;
                len[i]     <= '0;
                chars[i]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (keep) begin
                            weight[k] <= WGT_W'(in_freq);
                            active[k] <= 1'b1;
                            chars[k]  <= in_char;
                        end
                        k        <= k_next;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        if (load_exit) begin
                            xfer_cnt <= '0;
                            if (k_next == '0) begin
                                done <= 1'b1;
                            end else if (k_next == idx_t'(1)) begin
                                state    <= ST_EMIT;
                                in_ready <= 1'b0;
                                emit_idx <= '0;
                            end else begin
                                state    <= ST_BUILD;
                                in_ready <= 1'b0;
                                node_ptr <= k_next;
                                root_idx <= idx_t'(2 * k_next - 2);
                            end
                        end
                    end
                end

                ST_BUILD: begin
                    weight[node_ptr]  <= w_a + w_b;
                    left_c[node_ptr]  <= sel_a;
                    right_c[node_ptr] <= sel_b;
                    code[node_ptr]    <= '0;
                    len[node_ptr]     <= '0;
                    active[node_ptr]  <= 1'b1;
                    active[sel_a]     <= 1'b0;
                    active[sel_b]     <= 1'b0;
                    if (node_ptr == root_idx) begin
                        state <= ST_CODE;
                    end else begin
                        node_ptr <= node_ptr + 1'b1;
                    end
                end

                // Children always have lower indices than their parent, so a descending walk
                // from the root sees every parent code settled before it is extended.
                ST_CODE: begin
                    code[left_c[node_ptr]]  <= code[node_ptr] << 1;
                    code[right_c[node_ptr]] <= (code[node_ptr] << 1) | CODE_W'(1);
                    len[left_c[node_ptr]]   <= len[node_ptr] + 1'b1;
                    len[right_c[node_ptr]]  <= len[node_ptr] + 1'b1;
                    if (node_ptr == k) begin
                        state    <= ST_EMIT;
                        emit_idx <= '0;
                    end else begin
                        node_ptr <= node_ptr - 1'b1;
                    end
                end

                ST_EMIT: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && emit_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_LOAD;
                            in_ready  <= 1'b1;
                            k         <= '0;
                            active    <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            out_char  <= beat_char;
                            out_code  <= beat_code;
                            out_len   <= beat_len;
                            emit_idx  <= beat_idx;
                        end
                    end
                end

                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_encoder_stream.sv
// Bench for huff_encoder_stream: directed tables plus random tables checked against a
// bottom-up Huffman reference model (codes derived by walking leaf-to-root parent links).
module tb_huff_encoder_stream;

    localparam int MAXC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_char;
    logic [3:0] in_freq;
    logic       out_valid, out_ready, done;
    logic [7:0] out_char;
    logic [2:0] out_code;
    logic [1:0] out_len;

    int checks = 0;
    int errors = 0;

    huff_encoder_stream #(.MAX_CHAR_COUNT(MAXC), .CHAR_W(8), .FREQ_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_freq(in_freq), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .out_code(out_code), .out_len(out_len), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Table under test
    int tn;
    int tc [MAXC];
    int tf [MAXC];
    int tlast [MAXC];

    // Expected beats
    int ek;
    int e_char [MAXC];
    int e_code [MAXC];
    int e_len  [MAXC];

    task automatic build_model();
        int w [2*MAXC];
        bit act [2*MAXC];
        int par [2*MAXC];
        bit isr [2*MAXC];
        int nn, a, b, root, node, c, l, used;
        ek = 0;
        used = 0;
        for (int i = 0; i < tn; i++) begin
            used++;
            if (tf[i] != 0) begin
                w[ek] = tf[i]; act[ek] = 1; e_char[ek] = tc[i]; ek++;
            end
            if (tlast[i] != 0 || used == MAXC) break;
        end
        for (int i = ek; i < 2*MAXC; i++) act[i] = 0;
        nn = ek;
        for (int m = 0; m < ek - 1; m++) begin
            a = -1; b = -1;
            for (int i = 0; i < nn; i++) if (act[i] && (a < 0 || w[i] < w[a])) a = i;
            for (int i = 0; i < nn; i++) if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
            w[nn] = w[a] + w[b]; act[nn] = 1; act[a] = 0; act[b] = 0;
            par[a] = nn; par[b] = nn; isr[a] = 0; isr[b] = 1;
            nn++;
        end
        root = 2*ek - 2;
        for (int i = 0; i < ek; i++) begin
            c = 0; l = 0; node = i;
            while (node != root) begin
                c = c | (int'(isr[node]) << l);
                l++;
                node = par[node];
            end
            if (ek == 1) begin c = 0; l = 1; end
            e_code[i] = c; e_len[i] = l;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_table(input int nsend);
        for (int i = 0; i < nsend; i++) begin
            @(negedge clk);
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1; in_char = 8'(tc[i]); in_freq = 4'(tf[i]); in_last = tlast[i][0];
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // mode: 0 = out_ready always high, 1 = hold 3 cycles per beat, 2 = random hold 0..2
    task automatic run_table(input int mode);
        int cyc, hold, nsend;
        build_model();
        nsend = 0;
        for (int i = 0; i < tn; i++) begin
            nsend++;
            if (tlast[i] != 0 || nsend == MAXC) break;
        end
        out_ready = (mode == 0);
        send_table(nsend);
        if (ek == 0) begin
            check("empty_done", done, 1);
            check("empty_in_ready", in_ready, 1);
            @(negedge clk);
            check("empty_done_clr", done, 0);
            return;
        end
        check("busy_in_ready", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            check("early_done", done, 0);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 2*ek - 1);
        if (!out_valid) begin
            do_reset();
            return;
        end
        for (int b = 0; b < ek; b++) begin
            check("beat_valid", out_valid, 1);
            check("beat_char", out_char, e_char[b]);
            check("beat_code", out_code, e_code[b]);
            check("beat_len", out_len, e_len[b]);
            hold = (mode == 1) ? 3 : (mode == 2) ? $urandom_range(0, 2) : 0;
            if (hold > 0) begin
                out_ready = 1'b0;
                repeat (hold) begin
                    @(negedge clk);
                    check("bp_valid", out_valid, 1);
                    check("bp_char", out_char, e_char[b]);
                    check("bp_code", out_code, e_code[b]);
                    check("bp_len", out_len, e_len[b]);
                    check("bp_done", done, 0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        check("end_valid", out_valid, 0);
        check("end_done", done, 1);
        check("end_in_ready", in_ready, 1);
        @(negedge clk);
        check("done_clr", done, 0);
    endtask

    task automatic set_sym(input int i, input int c, input int f, input int l);
        tc[i] = c; tf[i] = f; tlast[i] = l;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_char = '0; in_freq = '0;
        out_ready = 1'b1;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_done", done, 0);
        check("reset_char", out_char, 0);
        check("reset_code", out_code, 0);
        check("reset_len", out_len, 0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1
        tn = 3; set_sym(0, "o", 3, 0); set_sym(1, "n", 1, 0); set_sym(2, "m", 2, 1);
        run_table(0);
        // Scenario 2, then again with backpressure
        tn = 4; set_sym(0, "a", 1, 0); set_sym(1, "b", 1, 0); set_sym(2, "c", 1, 0); set_sym(3, "d", 1, 1);
        run_table(0);
        run_table(1);
        // Scenario 3
        tn = 4; set_sym(0, "a", 1, 0); set_sym(1, "b", 2, 0); set_sym(2, "c", 4, 0); set_sym(3, "d", 8, 1);
        run_table(0);
        // Single symbol and empty table
        tn = 1; set_sym(0, "x", 5, 1);
        run_table(0);
        tn = 1; set_sym(0, "y", 0, 1);
        run_table(0);
        // Count limit without in_last, including a discarded symbol
        tn = 4; set_sym(0, "p", 2, 0); set_sym(1, "q", 0, 0); set_sym(2, "r", 7, 0); set_sym(3, "s", 3, 0);
        run_table(0);

        // Reset during BUILD of scenario 3, then scenario 1 again
        tn = 4; set_sym(0, "a", 1, 0); set_sym(1, "b", 2, 0); set_sym(2, "c", 4, 0); set_sym(3, "d", 8, 1);
        send_table(4);
        check("build_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        tn = 3; set_sym(0, "o", 3, 0); set_sym(1, "n", 1, 0); set_sym(2, "m", 2, 1);
        run_table(0);

        // Random tables
        for (int t = 0; t < 40; t++) begin
            tn = $urandom_range(1, MAXC);
            for (int i = 0; i < tn; i++) begin
                set_sym(i, $urandom_range(0, 255),
                        ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15),
                        (i == tn - 1 && (tn < MAXC || $urandom_range(0, 1) == 1)) ? 1 : 0);
            end
            run_table($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
